// File: rtl/tl_fragmenter_v2.sv
// TileLink fragmenter: splits multi-beat Get / PutFullData requests into
// single-beat TL-UL requests downstream and reassembles the D responses.
// One upstream transaction is in flight at a time.
module tl_fragmenter_v2 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 26,
    parameter int SRC_W  = 5,
    parameter int MAX_LG = 6
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  a_in_valid,
    output logic                  a_in_ready,
    input  logic [2:0]            a_in_opcode,
    input  logic [2:0]            a_in_param,
    input  logic [2:0]            a_in_size,
    input  logic [SRC_W-1:0]      a_in_source,
    input  logic [ADDR_W-1:0]     a_in_address,
    input  logic [DATA_W/8-1:0]   a_in_mask,
    input  logic [DATA_W-1:0]     a_in_data,

    output logic                  a_out_valid,
    input  logic                  a_out_ready,
    output logic [2:0]            a_out_opcode,
    output logic [2:0]            a_out_param,
    output logic [2:0]            a_out_size,
    output logic [SRC_W-1:0]      a_out_source,
    output logic [ADDR_W-1:0]     a_out_address,
    output logic [DATA_W/8-1:0]   a_out_mask,
    output logic [DATA_W-1:0]     a_out_data,

    input  logic                  d_in_valid,
    output logic                  d_in_ready,
    input  logic [2:0]            d_in_opcode,
    input  logic [2:0]            d_in_size,
    input  logic [SRC_W-1:0]      d_in_source,
    input  logic                  d_in_denied,
    input  logic                  d_in_corrupt,
    input  logic [DATA_W-1:0]     d_in_data,

    output logic                  d_out_valid,
    input  logic                  d_out_ready,
    output logic [2:0]            d_out_opcode,
    output logic [2:0]            d_out_size,
    output logic [SRC_W-1:0]      d_out_source,
    output logic                  d_out_denied,
    output logic                  d_out_corrupt,
    output logic [DATA_W-1:0]     d_out_data,

    output logic                  protocol_err
);

    localparam int         BEAT_LG    = $clog2(DATA_W / 8);
    localparam int         MW         = DATA_W / 8;
    localparam int         CW         = MAX_LG - BEAT_LG + 1;
    localparam logic [2:0] BEAT_SZ    = 3'(BEAT_LG);
    localparam logic [2:0] MAX_SZ     = 3'(MAX_LG);
    localparam logic [2:0] OP_PUTFULL = 3'd0;
    localparam logic [2:0] OP_GET     = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_GET  = 2'd2,
        S_PUT  = 2'd3
    } state_e;

    // Index of the last fragment for a legal fragmentable size.
    function automatic logic [CW-1:0] frag_last(input logic [2:0] sz);
        logic [CW-1:0] one;
        logic [2:0]    sh;
        one       = CW'(1);
        sh        = sz - BEAT_SZ;
        frag_last = (one << sh) - one;
    endfunction

    state_e              state_q;
    logic [2:0]          size_q;
    logic [2:0]          opcode_q;
    logic [2:0]          param_q;
    logic [SRC_W-1:0]    src_q;
    logic [ADDR_W-1:0]   base_q;
    logic [CW-1:0]       last_q;
    logic [CW-1:0]       a_cnt_q;
    logic [CW-1:0]       d_cnt_q;
    logic                den_q;
    logic                cor_q;
    logic                perr_q;

    logic                is_big_s;
    logic                too_big_s;
    logic                go_get_s;
    logic                go_put_s;
    logic                err_s;
    logic                a_more_s;
    logic                d_last_s;
    logic                a_acc_s;
    logic                a_fire_s;
    logic                d_fire_s;
    logic [ADDR_W-1:0]   frag_addr_s;

    // Classify the incoming request and derive handshake qualifiers.
    always_comb begin
        is_big_s    = (a_in_size > BEAT_SZ);
        too_big_s   = (a_in_size > MAX_SZ);
        go_get_s    = is_big_s && !too_big_s && (a_in_opcode == OP_GET);
        go_put_s    = is_big_s && !too_big_s && (a_in_opcode == OP_PUTFULL);
        err_s       = is_big_s && !go_get_s && !go_put_s;
        a_more_s    = (a_cnt_q <= last_q);
        d_last_s    = (d_cnt_q == last_q);
        frag_addr_s = base_q + (ADDR_W'(a_cnt_q) << BEAT_LG);
        a_acc_s     = a_in_valid && a_in_ready;
        a_fire_s    = a_out_valid && a_out_ready;
        d_fire_s    = d_in_valid && d_in_ready;
    end

    // Output muxing: passthrough by default, overridden per state.
    always_comb begin
        a_in_ready    = 1'b0;
        a_out_valid   = 1'b0;
        a_out_opcode  = a_in_opcode;
        a_out_param   = a_in_param;
        a_out_size    = a_in_size;
        a_out_source  = a_in_source;
        a_out_address = a_in_address;
        a_out_mask    = a_in_mask;
        a_out_data    = a_in_data;
        d_in_ready    = 1'b0;
        d_out_valid   = 1'b0;
        d_out_opcode  = d_in_opcode;
        d_out_size    = d_in_size;
        d_out_source  = d_in_source;
        d_out_denied  = d_in_denied;
        d_out_corrupt = d_in_corrupt;
        d_out_data    = d_in_data;
        case (state_q)
            S_IDLE: begin
                // Gets are latched and replayed; everything else goes straight through.
                a_out_valid = a_in_valid && !go_get_s;
                a_in_ready  = go_get_s ? 1'b1 : a_out_ready;
                a_out_size  = go_put_s ? BEAT_SZ : a_in_size;
            end
            S_PASS: begin
                d_out_valid = d_in_valid;
                d_in_ready  = d_out_ready;
            end
            S_GET: begin
                a_out_valid   = a_more_s;
                a_out_opcode  = OP_GET;
                a_out_param   = param_q;
                a_out_size    = BEAT_SZ;
                a_out_source  = src_q;
                a_out_address = frag_addr_s;
                a_out_mask    = {MW{1'b1}};
                a_out_data    = {DATA_W{1'b0}};
                d_out_valid   = d_in_valid;
                d_in_ready    = d_out_ready;
                d_out_size    = size_q;
            end
            S_PUT: begin
                a_out_valid   = a_in_valid && a_more_s;
                a_in_ready    = a_out_ready && a_more_s;
                a_out_opcode  = opcode_q;
                a_out_param   = param_q;
                a_out_size    = BEAT_SZ;
                a_out_source  = src_q;
                a_out_address = frag_addr_s;
                // Intermediate acks are swallowed; the final one carries the merged status.
                d_out_valid   = d_last_s ? d_in_valid : 1'b0;
                d_in_ready    = d_last_s ? d_out_ready : 1'b1;
                d_out_size    = size_q;
                d_out_denied  = den_q || d_in_denied;
                d_out_corrupt = cor_q || d_in_corrupt;
            end
            default: begin
                a_out_valid = 1'b0;
            end
        endcase
    end

    assign protocol_err = perr_q;

    // Transaction FSM, fragment counters, status accumulators and error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            size_q   <= 3'd0;
            opcode_q <= 3'd0;
            param_q  <= 3'd0;
            src_q    <= {SRC_W{1'b0}};
            base_q   <= {ADDR_W{1'b0}};
            last_q   <= {CW{1'b0}};
            a_cnt_q  <= {CW{1'b0}};
            d_cnt_q  <= {CW{1'b0}};
            den_q    <= 1'b0;
            cor_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (a_acc_s) begin
                        size_q   <= a_in_size;
                        opcode_q <= a_in_opcode;
                        param_q  <= a_in_param;
                        src_q    <= a_in_source;
                        base_q   <= a_in_address;
                        last_q   <= frag_last(a_in_size);
                        // Put beat 0 already left in this cycle.
                        a_cnt_q  <= go_put_s ? CW'(1) : {CW{1'b0}};
                        d_cnt_q  <= {CW{1'b0}};
                        den_q    <= 1'b0;
                        cor_q    <= 1'b0;
                        if (err_s) begin
                            perr_q <= 1'b1;
                        end
                        if (go_get_s) begin
                            state_q <= S_GET;
                        end else if (go_put_s) begin
                            state_q <= S_PUT;
                        end else begin
                            state_q <= S_PASS;
                        end
                    end
                end
                S_PASS: begin
                    if (d_fire_s) begin
                        state_q <= S_IDLE;
                    end
                end
                S_GET, S_PUT: begin
                    if (a_fire_s) begin
                        a_cnt_q <= a_cnt_q + CW'(1);
                    end
                    if (d_fire_s) begin
                        d_cnt_q <= d_cnt_q + CW'(1);
                        den_q   <= den_q || d_in_denied;
                        cor_q   <= cor_q || d_in_corrupt;
                        if (d_last_s) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tl_fragmenter_v2.sv
// Directed self-checking bench for tl_fragmenter_v2 at DATA_W=32.
module tb_tl_fragmenter_v2;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 26;
    localparam int SRC_W  = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              a_in_valid, a_in_ready;
    logic [2:0]        a_in_opcode, a_in_param, a_in_size;
    logic [SRC_W-1:0]  a_in_source;
    logic [ADDR_W-1:0] a_in_address;
    logic [3:0]        a_in_mask;
    logic [DATA_W-1:0] a_in_data;
    logic              a_out_valid, a_out_ready;
    logic [2:0]        a_out_opcode, a_out_param, a_out_size;
    logic [SRC_W-1:0]  a_out_source;
    logic [ADDR_W-1:0] a_out_address;
    logic [3:0]        a_out_mask;
    logic [DATA_W-1:0] a_out_data;
    logic              d_in_valid, d_in_ready;
    logic [2:0]        d_in_opcode, d_in_size;
    logic [SRC_W-1:0]  d_in_source;
    logic              d_in_denied, d_in_corrupt;
    logic [DATA_W-1:0] d_in_data;
    logic              d_out_valid, d_out_ready;
    logic [2:0]        d_out_opcode, d_out_size;
    logic [SRC_W-1:0]  d_out_source;
    logic              d_out_denied, d_out_corrupt;
    logic [DATA_W-1:0] d_out_data;
    logic              protocol_err;

    int checks   = 0;
    int failures = 0;

    tl_fragmenter_v2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRC_W(SRC_W), .MAX_LG(6)) dut (
        .clock(clock), .reset(reset),
        .a_in_valid(a_in_valid), .a_in_ready(a_in_ready), .a_in_opcode(a_in_opcode),
        .a_in_param(a_in_param), .a_in_size(a_in_size), .a_in_source(a_in_source),
        .a_in_address(a_in_address), .a_in_mask(a_in_mask), .a_in_data(a_in_data),
        .a_out_valid(a_out_valid), .a_out_ready(a_out_ready), .a_out_opcode(a_out_opcode),
        .a_out_param(a_out_param), .a_out_size(a_out_size), .a_out_source(a_out_source),
        .a_out_address(a_out_address), .a_out_mask(a_out_mask), .a_out_data(a_out_data),
        .d_in_valid(d_in_valid), .d_in_ready(d_in_ready), .d_in_opcode(d_in_opcode),
        .d_in_size(d_in_size), .d_in_source(d_in_source), .d_in_denied(d_in_denied),
        .d_in_corrupt(d_in_corrupt), .d_in_data(d_in_data),
        .d_out_valid(d_out_valid), .d_out_ready(d_out_ready), .d_out_opcode(d_out_opcode),
        .d_out_size(d_out_size), .d_out_source(d_out_source), .d_out_denied(d_out_denied),
        .d_out_corrupt(d_out_corrupt), .d_out_data(d_out_data),
        .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drv_a(input logic v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [SRC_W-1:0] src, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data);
        a_in_valid   = v;
        a_in_opcode  = op;
        a_in_param   = 3'd0;
        a_in_size    = sz;
        a_in_source  = src;
        a_in_address = addr;
        a_in_mask    = 4'hF;
        a_in_data    = data;
    endtask

    task automatic drv_d(input logic v, input logic [2:0] op, input logic [SRC_W-1:0] src,
                         input logic den, input logic cor, input logic [DATA_W-1:0] data);
        d_in_valid   = v;
        d_in_opcode  = op;
        d_in_size    = 3'd2;
        d_in_source  = src;
        d_in_denied  = den;
        d_in_corrupt = cor;
        d_in_data    = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        a_out_ready = 1'b1;
        d_out_ready = 1'b1;
        drv_a(1'b0, 3'd0, 3'd0, 5'd0, 26'h0, 32'h0);
        drv_d(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        #1;
        chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_d_out_valid", 64'(d_out_valid), 64'd0);
        chk("rst_perr", 64'(protocol_err), 64'd0);
        chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_d_in_ready", 64'(d_in_ready), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        cyc();

        // Get S=4 at 0x100, source 3
        drv_a(1'b1, 3'd4, 3'd4, 5'd3, 26'h100, 32'h0);
        #1;
        chk("get_acc_ready", 64'(a_in_ready), 64'd1);
        chk("get_acc_noout", 64'(a_out_valid), 64'd0);
        cyc();
        a_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("get_a_valid", 64'(a_out_valid), 64'd1);
            chk("get_a_addr", 64'(a_out_address), 64'h100 + 64'(4 * k));
            chk("get_a_size", 64'(a_out_size), 64'd2);
            chk("get_a_src", 64'(a_out_source), 64'd3);
            chk("get_a_op", 64'(a_out_opcode), 64'd4);
            chk("get_a_mask", 64'(a_out_mask), 64'hF);
            chk("get_busy", 64'(a_in_ready), 64'd0);
            cyc();
        end
        #1;
        chk("get_a_done", 64'(a_out_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            drv_d(1'b1, 3'd1, 5'd3, 1'b0, 1'b0, 32'hD0 + 32'(k));
            #1;
            chk("get_d_valid", 64'(d_out_valid), 64'd1);
            chk("get_d_size", 64'(d_out_size), 64'd4);
            chk("get_d_src", 64'(d_out_source), 64'd3);
            chk("get_d_data", 64'(d_out_data), 64'hD0 + 64'(k));
            chk("get_d_busy", 64'(a_in_ready), 64'd0);
            cyc();
        end
        d_in_valid = 1'b0;
        #1;
        chk("get_idle_ready", 64'(a_in_ready), 64'd1);
        chk("get_idle_dready", 64'(d_in_ready), 64'd0);

        // Get S=4 at 0x200 with a 5-cycle upstream D stall
        drv_a(1'b1, 3'd4, 3'd4, 5'd5, 26'h200, 32'h0);
        cyc();
        a_in_valid = 1'b0;
        #1;
        chk("stall_a0", 64'(a_out_address), 64'h200);
        cyc();
        drv_d(1'b1, 3'd1, 5'd5, 1'b0, 1'b0, 32'h50);
        #1;
        chk("stall_a1", 64'(a_out_address), 64'h204);
        chk("stall_d0", 64'(d_out_data), 64'h50);
        cyc();
        d_out_ready = 1'b0;
        d_in_data   = 32'h51;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_dready", 64'(d_in_ready), 64'd0);
            if (i < 2) begin
                chk("stall_a_valid", 64'(a_out_valid), 64'd1);
                chk("stall_a_addr", 64'(a_out_address), 64'h208 + 64'(4 * i));
            end else begin
                chk("stall_a_done", 64'(a_out_valid), 64'd0);
            end
            cyc();
        end
        d_out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            d_in_data = 32'h50 + 32'(k);
            #1;
            chk("stall_d_ready", 64'(d_in_ready), 64'd1);
            chk("stall_d_data", 64'(d_out_data), 64'h50 + 64'(k));
            chk("stall_busy", 64'(a_in_ready), 64'd0);
            cyc();
        end
        d_in_valid = 1'b0;
        #1;
        chk("stall_idle", 64'(a_in_ready), 64'd1);

        // PutFull S=3 at 0x40, source 2
        drv_a(1'b1, 3'd0, 3'd3, 5'd2, 26'h40, 32'hAAAA_0001);
        #1;
        chk("put_b0_valid", 64'(a_out_valid), 64'd1);
        chk("put_b0_addr", 64'(a_out_address), 64'h40);
        chk("put_b0_size", 64'(a_out_size), 64'd2);
        chk("put_b0_data", 64'(a_out_data), 64'hAAAA_0001);
        chk("put_b0_ready", 64'(a_in_ready), 64'd1);
        cyc();
        a_in_data = 32'hBBBB_0002;
        #1;
        chk("put_b1_valid", 64'(a_out_valid), 64'd1);
        chk("put_b1_addr", 64'(a_out_address), 64'h44);
        chk("put_b1_data", 64'(a_out_data), 64'hBBBB_0002);
        chk("put_b1_size", 64'(a_out_size), 64'd2);
        cyc();
        a_in_valid = 1'b0;
        #1;
        chk("put_a_done", 64'(a_out_valid), 64'd0);
        chk("put_busy", 64'(a_in_ready), 64'd0);
        drv_d(1'b1, 3'd0, 5'd2, 1'b0, 1'b0, 32'h0);
        #1;
        chk("put_ack0_ready", 64'(d_in_ready), 64'd1);
        chk("put_ack0_hidden", 64'(d_out_valid), 64'd0);
        cyc();
        #1;
        chk("put_ack1_valid", 64'(d_out_valid), 64'd1);
        chk("put_ack1_size", 64'(d_out_size), 64'd3);
        chk("put_ack1_op", 64'(d_out_opcode), 64'd0);
        chk("put_ack1_src", 64'(d_out_source), 64'd2);
        chk("put_ack1_den", 64'(d_out_denied), 64'd0);
        cyc();
        d_in_valid = 1'b0;

        // PutFull S=4 at 0x80, denied on fragment 1 only
        for (int k = 0; k < 4; k++) begin
            drv_a(1'b1, 3'd0, 3'd4, 5'd1, 26'h80, 32'h1000 + 32'(k));
            #1;
            chk("putd_addr", 64'(a_out_address), 64'h80 + 64'(4 * k));
            chk("putd_data", 64'(a_out_data), 64'h1000 + 64'(k));
            cyc();
        end
        a_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drv_d(1'b1, 3'd0, 5'd1, (k == 1), 1'b0, 32'h0);
            #1;
            if (k < 3) begin
                chk("putd_hidden", 64'(d_out_valid), 64'd0);
            end else begin
                chk("putd_final", 64'(d_out_valid), 64'd1);
                chk("putd_denied", 64'(d_out_denied), 64'd1);
                chk("putd_corrupt", 64'(d_out_corrupt), 64'd0);
                chk("putd_size", 64'(d_out_size), 64'd4);
            end
            cyc();
        end
        d_in_valid = 1'b0;

        // Get S=2: single beat passthrough
        drv_a(1'b1, 3'd4, 3'd2, 5'd7, 26'h10, 32'h0);
        a_out_ready = 1'b0;
        #1;
        chk("pass_bp_ready", 64'(a_in_ready), 64'd0);
        chk("pass_valid", 64'(a_out_valid), 64'd1);
        a_out_ready = 1'b1;
        #1;
        chk("pass_ready", 64'(a_in_ready), 64'd1);
        chk("pass_size", 64'(a_out_size), 64'd2);
        chk("pass_addr", 64'(a_out_address), 64'h10);
        cyc();
        a_in_valid = 1'b0;
        #1;
        chk("pass_a_done", 64'(a_out_valid), 64'd0);
        drv_d(1'b1, 3'd1, 5'd7, 1'b0, 1'b0, 32'hCAFE);
        #1;
        chk("pass_d_size", 64'(d_out_size), 64'd2);
        chk("pass_d_data", 64'(d_out_data), 64'hCAFE);
        cyc();
        d_in_valid = 1'b0;
        #1;
        chk("pass_perr", 64'(protocol_err), 64'd0);

        // Reset in the middle of a Get after two fragments
        drv_a(1'b1, 3'd4, 3'd4, 5'd4, 26'h300, 32'h0);
        cyc();
        a_in_valid = 1'b0;
        cyc();
        cyc();
        drv_d(1'b1, 3'd1, 5'd4, 1'b0, 1'b0, 32'h77);
        #1;
        reset = 1'b0;
        #1;
        chk("mrst_a_valid", 64'(a_out_valid), 64'd0);
        chk("mrst_d_valid", 64'(d_out_valid), 64'd0);
        chk("mrst_d_ready", 64'(d_in_ready), 64'd0);
        d_in_valid = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        drv_a(1'b1, 3'd0, 3'd3, 5'd9, 26'h60, 32'h1111_2222);
        #1;
        chk("mrst_put_b0", 64'(a_out_address), 64'h60);
        chk("mrst_put_b0v", 64'(a_out_valid), 64'd1);
        cyc();
        a_in_data = 32'h3333_4444;
        #1;
        chk("mrst_put_b1", 64'(a_out_address), 64'h64);
        cyc();
        a_in_valid = 1'b0;
        drv_d(1'b1, 3'd0, 5'd9, 1'b0, 1'b0, 32'h0);
        #1;
        chk("mrst_ack0", 64'(d_out_valid), 64'd0);
        cyc();
        #1;
        chk("mrst_ack1", 64'(d_out_valid), 64'd1);
        chk("mrst_ack1_size", 64'(d_out_size), 64'd3);
        cyc();
        d_in_valid = 1'b0;
        #1;
        chk("mrst_idle", 64'(a_in_ready), 64'd1);

        // ArithmeticData S=4: unsupported, passed unfragmented
        drv_a(1'b1, 3'd2, 3'd4, 5'd6, 26'h400, 32'h5);
        #1;
        chk("arith_valid", 64'(a_out_valid), 64'd1);
        chk("arith_size", 64'(a_out_size), 64'd4);
        chk("arith_op", 64'(a_out_opcode), 64'd2);
        chk("arith_perr_pre", 64'(protocol_err), 64'd0);
        cyc();
        a_in_valid = 1'b0;
        #1;
        chk("arith_perr", 64'(protocol_err), 64'd1);
        chk("arith_a_done", 64'(a_out_valid), 64'd0);
        drv_d(1'b1, 3'd1, 5'd6, 1'b0, 1'b0, 32'h9);
        d_in_size = 3'd4;
        #1;
        chk("arith_d_size", 64'(d_out_size), 64'd4);
        chk("arith_d_valid", 64'(d_out_valid), 64'd1);
        cyc();
        d_in_valid = 1'b0;
        drv_a(1'b1, 3'd4, 3'd2, 5'd6, 26'h20, 32'h0);
        cyc();
        a_in_valid = 1'b0;
        drv_d(1'b1, 3'd1, 5'd6, 1'b0, 1'b0, 32'h1);
        cyc();
        d_in_valid = 1'b0;
        #1;
        chk("arith_perr_held", 64'(protocol_err), 64'd1);
        chk("arith_idle", 64'(a_in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tl_fragmenter_v2.md
Name: tl_fragmenter_v2

Overview:
- Parametrised successor to the single-configuration TL fragmenter wrapper.
- Splits upstream Get / PutFullData requests larger than one data beat into beat-sized TL-UL requests on the downstream port.
- Reassembles the responses: Get beats are returned as a multi-beat response; Put acks are collapsed into a single AccessAck.
- Sits between the core-side crossbar and narrow peripheral buses; one upstream transaction in flight at a time.

Parameters:
DATA_W, 32, data bus width in bits; power of two, at least 8.
ADDR_W, 26, address width.
SRC_W, 5, source ID width; the same width is used on both sides.
MAX_LG, 6, log2 of the largest upstream transfer in bytes.
BEAT_LG, derived as log2(DATA_W/8), log2 bytes per beat. Not overridable.

Ports:
clock  in  1  clock.
reset  in  1  asynchronous, active-low reset.
a_in_valid / a_in_ready  in/out  1  upstream A handshake.
a_in_opcode  in  3  upstream A opcode.
a_in_param  in  3  upstream A param.
a_in_size  in  3  upstream A log2 size.
a_in_source  in  SRC_W  upstream A source.
a_in_address  in  ADDR_W  upstream A address.
a_in_mask  in  DATA_W/8  upstream A byte mask.
a_in_data  in  DATA_W  upstream A data.
a_out_*  out  (same set and widths as a_in_*)  downstream A; a_out_ready is an input.
d_in_valid / d_in_ready  in/out  1  downstream D handshake.
d_in_opcode  in  3  downstream D opcode.
d_in_size  in  3  downstream D size.
d_in_source  in  SRC_W  downstream D source.
d_in_denied  in  1  downstream D denied.
d_in_corrupt  in  1  downstream D corrupt.
d_in_data  in  DATA_W  downstream D data.
d_out_*  out  (same set and widths as d_in_*)  upstream D; d_out_ready is an input.
protocol_err  out  1  sticky flag for unsupported fragmentation.

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE; all counters and denied/corrupt accumulators clear.
  - a_out_valid=0, d_out_valid=0, protocol_err=0.
  - a_in_ready=1 and d_in_ready=0 while idle.
  - Reset mid-transaction abandons it; no residual output.
- Fragment count: N = 2^(S-BEAT_LG) when S>BEAT_LG, otherwise 1. S is the latched a_in_size.
- FSM states:
  - IDLE: a_in accepted. Go to GET when opcode=4 and S>BEAT_LG; go to PUT when opcode=0 and S>BEAT_LG; otherwise go to PASS.
  - PASS: the single request is forwarded combinationally in the accept cycle (a_out=a_in, a_in_ready=a_out_ready). The FSM waits for one D beat, passes it through unchanged, then returns to IDLE.
  - GET:
    - Request latched on accept; a_in_ready=0 until return to IDLE.
    - Fragment k (0..N-1) is issued from registers: size=BEAT_LG, address=base+(k<<BEAT_LG), mask all-ones, same source/param.
    - First a_out_valid occurs the cycle after accept; a_cnt advances on each a_out fire.
  - PUT:
    - Each upstream beat is forwarded with zero latency: a_out_valid=a_in_valid, a_in_ready=a_out_ready.
    - Size is forced to BEAT_LG; address = latched base + (a_cnt<<BEAT_LG); data and mask are taken from the beat.
    - Beat 0 uses a_in_address directly.
- D path (GET/PUT):
  - GET: each AccessAckData (opcode 1) is forwarded as one beat with d_out_size=S, d_in_ready=d_out_ready.
  - PUT: acks for fragments 0..N-2 are absorbed (d_in_ready=1, d_out_valid=0); the ack for fragment N-1 is forwarded with size S.
  - d_cnt advances per D fire.
  - denied/corrupt: GET beats carry their own flags; the final PUT ack carries the OR over all fragments.
- Return to IDLE: on the final D fire (d_cnt=N-1). a_in may be accepted in the following cycle, never the same cycle.
- Simultaneous events: a D fire in the same cycle as the last A fire is legal and both counters update.
- Counters are MAX_LG-BEAT_LG+1 bits wide and never wrap within a transaction.
- Unsupported cases (opcode not 0/4 with S>BEAT_LG, or S>MAX_LG):
  - Handled as PASS, unfragmented.
  - protocol_err is set and held until reset.

Test Plan:
- DATA_W=32: Get S=4, addr 0x100, src 3 -> a_out Gets at 0x100/0x104/0x108/0x10C, size 2; 4 d_out beats with size 4, src 3; a_in_ready low until the 4th d_out fire.
- PutFull S=3, data 0xAAAA_0001 then 0xBBBB_0002, mask 0xF -> two a_out Puts at base and base+4; first AccessAck absorbed; one d_out AccessAck with size 3.
- Put S=4 with denied=1 on fragment 1 only -> single d_out ack with denied=1; the other 3 acks are not visible upstream.
- Get S=2 (one beat) -> zero-latency passthrough, size 2 unchanged, protocol_err=0.
- d_out_ready held low 5 cycles mid-Get -> d_in_ready low for those cycles, no beat lost or duplicated; a_out issue continues.
- reset low mid-Get after 2 fragments -> all valids 0 immediately; after release a new Put S=3 completes normally.
- ArithmeticData S=4 -> forwarded unfragmented; protocol_err=1 and held.
